// File: rtl/exe_mem_pkg.sv
// Shared widths, payload layout and pure capture-time helpers for the EXE/MEM pipeline register.
package exe_mem_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 16;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]     result;
        logic [DATA_W_DEF-1:0]     rt_data;
        logic [ADDR_W_DEF-1:0]     branch_addr;
        logic [REG_ADDR_W_DEF-1:0] dst_reg;
        logic                      zero;
        logic                      branch_taken;
        logic                      mem_read;
        logic                      mem_write;
        logic                      mem_to_reg;
        logic                      reg_write;
    } exe_mem_payload_t;

    // beq and bne together always resolve as taken
    function automatic logic f_branch_taken(input logic beq, input logic bne, input logic zero);
        return (beq & zero) | (bne & ~zero);
    endfunction

    function automatic logic f_reg_write(input logic suppress, input logic dst_is_zero,
                                         input logic reg_write);
        return reg_write & ~(suppress & dst_is_zero);
    endfunction

endpackage

// File: rtl/exe_mem_slot.sv
// One payload holding register with a valid bit; used for both the main and the skid entry.
module exe_mem_slot
    import exe_mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Clear only drops the valid bit; payload is left as-is since it is ignored while invalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= {W{1'b0}};
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE/MEM pipeline register with valid/ready handshake and a one-entry skid buffer so that
// in_ready is a pure register output with no combinational path from out_ready.
module exe_mem_pipe_reg
    import exe_mem_pkg::*;
#(
    parameter int DATA_W            = DATA_W_DEF,
    parameter int ADDR_W            = ADDR_W_DEF,
    parameter int REG_ADDR_W        = REG_ADDR_W_DEF,
    parameter int CNT_W             = CNT_W_DEF,
    parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic [DATA_W-1:0]     in_rt_data,
    input  logic [ADDR_W-1:0]     in_branch_addr,
    input  logic [REG_ADDR_W-1:0] in_dst_reg,
    input  logic                  in_zero,
    input  logic                  in_beq,
    input  logic                  in_bne,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic                  in_mem_to_reg,
    input  logic                  in_reg_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [DATA_W-1:0]     out_rt_data,
    output logic [ADDR_W-1:0]     out_branch_addr,
    output logic [REG_ADDR_W-1:0] out_dst_reg,
    output logic                  out_zero,
    output logic                  out_mem_to_reg,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_reg_write,
    output logic                  out_branch_taken,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int PAY_W = 2 * DATA_W + ADDR_W + REG_ADDR_W + 6;

    logic             w_main_valid;
    logic [PAY_W-1:0] w_main_data;
    logic             w_skid_valid;
    logic [PAY_W-1:0] w_skid_data;
    logic [PAY_W-1:0] w_cap;
    logic             w_in_fire;
    logic             w_main_en;
    logic             w_stall;
    logic             w_taken;
    logic             w_reg_write;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_taken     = f_branch_taken(in_beq, in_bne, in_zero);
    assign w_reg_write = f_reg_write(ZERO_REG_SUPPRESS, in_dst_reg == {REG_ADDR_W{1'b0}},
                                     in_reg_write);
    assign w_cap = {in_result, in_rt_data, in_branch_addr, in_dst_reg, in_zero, w_taken,
                    in_mem_read, in_mem_write, in_mem_to_reg, w_reg_write};

    assign in_ready  = ~w_skid_valid;
    assign w_in_fire = in_valid & ~w_skid_valid;
    assign w_main_en = ~w_main_valid | out_ready;
    assign w_stall   = w_main_valid & ~out_ready;

    // Skid contents take precedence so FIFO order is kept when the main entry frees up
    exe_mem_slot #(.W(PAY_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_load  (w_main_en),
        .i_valid (w_skid_valid | w_in_fire),
        .i_data  (w_skid_valid ? w_skid_data : w_cap),
        .o_valid (w_main_valid),
        .o_data  (w_main_data)
    );

    exe_mem_slot #(.W(PAY_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_load  ((w_in_fire & ~w_main_en) | (w_skid_valid & w_main_en)),
        .i_valid (w_in_fire & ~w_main_en),
        .i_data  (w_cap),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    // Saturating stall counter; survives flush and only clears on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cycles = r_stall_cnt;
    assign out_valid    = w_main_valid;

    assign {out_result, out_rt_data, out_branch_addr, out_dst_reg, out_zero}
        = w_main_data[PAY_W-1:5];
    assign out_branch_taken = w_main_data[4] & w_main_valid;
    assign out_mem_read     = w_main_data[3] & w_main_valid;
    assign out_mem_write    = w_main_data[2] & w_main_valid;
    assign out_mem_to_reg   = w_main_data[1];
    assign out_reg_write    = w_main_data[0] & w_main_valid;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Randomised and directed bench for exe_mem_pipe_reg against a two-deep FIFO reference model.
module tb_exe_mem_pipe_reg;
    import exe_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_result, in_rt_data, in_branch_addr;
    logic [4:0]  in_dst_reg;
    logic        in_zero, in_beq, in_bne, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write;

    logic        in_ready, out_valid;
    logic [31:0] out_result, out_rt_data, out_branch_addr;
    logic [4:0]  out_dst_reg;
    logic        out_zero, out_mem_to_reg, out_mem_read, out_mem_write, out_reg_write;
    logic        out_branch_taken;
    logic [15:0] stall_cycles;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_result, s_rt_data, s_branch_addr;
    logic [4:0]  s_dst_reg;
    logic        s_zero, s_m2r, s_mr, s_mw, s_rw, s_taken;
    logic [3:0]  stall4;

    int checks = 0;
    int errors = 0;
    exe_mem_payload_t q[$];
    int m_cnt, m_cnt4;

    always #5 clk = ~clk;

    exe_mem_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_rt_data(in_rt_data), .in_branch_addr(in_branch_addr),
        .in_dst_reg(in_dst_reg), .in_zero(in_zero), .in_beq(in_beq), .in_bne(in_bne),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
        .in_reg_write(in_reg_write), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rt_data(out_rt_data), .out_branch_addr(out_branch_addr),
        .out_dst_reg(out_dst_reg), .out_zero(out_zero), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .out_branch_taken(out_branch_taken),
        .stall_cycles(stall_cycles)
    );

    exe_mem_pipe_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_result(in_result), .in_rt_data(in_rt_data), .in_branch_addr(in_branch_addr),
        .in_dst_reg(in_dst_reg), .in_zero(in_zero), .in_beq(in_beq), .in_bne(in_bne),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
        .in_reg_write(in_reg_write), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_result(s_result), .out_rt_data(s_rt_data), .out_branch_addr(s_branch_addr),
        .out_dst_reg(s_dst_reg), .out_zero(s_zero), .out_mem_to_reg(s_m2r),
        .out_mem_read(s_mr), .out_mem_write(s_mw), .out_reg_write(s_rw),
        .out_branch_taken(s_taken), .stall_cycles(stall4)
    );

    function automatic exe_mem_payload_t expect_beat();
        exe_mem_payload_t b;
        b.result       = in_result;
        b.rt_data      = in_rt_data;
        b.branch_addr  = in_branch_addr;
        b.dst_reg      = in_dst_reg;
        b.zero         = in_zero;
        if (in_beq && in_bne)      b.branch_taken = 1'b1;
        else if (in_beq)           b.branch_taken = in_zero;
        else if (in_bne)           b.branch_taken = !in_zero;
        else                       b.branch_taken = 1'b0;
        b.mem_read     = in_mem_read;
        b.mem_write    = in_mem_write;
        b.mem_to_reg   = in_mem_to_reg;
        b.reg_write    = (in_dst_reg == 5'd0) ? 1'b0 : in_reg_write;
        return b;
    endfunction

    task automatic rand_payload();
        in_result      = $urandom;
        in_rt_data     = $urandom;
        in_branch_addr = $urandom;
        in_dst_reg     = 5'($urandom_range(0, 31));
        {in_zero, in_beq, in_bne, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write}
            = 7'($urandom_range(0, 127));
    endtask

    // Advance one clock; the model is a two-deep FIFO whose head is the visible beat
    task automatic step();
        bit fire;
        exe_mem_payload_t b;
        @(posedge clk);
        if (!rst) begin
            if (q.size() > 0 && !out_ready) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush) begin
                q.delete();
            end else begin
                fire = in_valid && (q.size() < 2);
                b = expect_beat();
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (fire) q.push_back(b);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b0;
        q.delete(); m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_payload(); in_mem_write = 1'b1; in_dst_reg = 5'd7; in_reg_write = 1'b1;
            in_valid = 1'b1;
            step();
        end
        rand_payload(); in_valid = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b want 0", out_valid);
        end
        checks++;
        if ({out_result, out_rt_data, out_branch_addr, out_dst_reg, out_zero, out_mem_to_reg,
             out_mem_read, out_mem_write, out_reg_write, out_branch_taken} !== 107'd0) begin
            errors++; $display("FAIL reset_payload: got result=%h dst=%0d mw=%0b want all zero",
                               out_result, out_dst_reg, out_mem_write);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        q.delete(); m_cnt = 0; m_cnt4 = 0;
        step();
        checks++;
        if (in_ready !== 1'b1 || stall_cycles !== 16'd0) begin
            errors++; $display("FAIL reset_release: got in_ready=%0b stall=%0d want 1 and 0",
                               in_ready, stall_cycles);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_payload(); in_result = 32'h11 * (i + 1); in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready: beat %0d got %0b want 1", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'h11 * (i + 1)) begin
                errors++; $display("FAIL stream_data: beat %0d got v=%0b %h want v=1 %h",
                                   i, out_valid, out_result, 32'h11 * (i + 1));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [31:0] vals[3];
        logic [31:0] want[3];
        vals = '{32'hA, 32'hB, 32'hC};
        want = '{32'hB, 32'hC, 32'h0};
        do_reset();
        out_ready = 1'b0;
        rand_payload(); in_valid = 1'b1; in_result = vals[0]; step();
        in_result = vals[1]; step();
        in_result = vals[2]; step(); step();
        checks++;
        if (out_result !== 32'hA || out_valid !== 1'b1 || in_ready !== 1'b0
            || stall_cycles !== 16'd3) begin
            errors++; $display("FAIL stall_hold: got r=%h v=%0b rdy=%0b cnt=%0d want A 1 0 3",
                               out_result, out_valid, in_ready, stall_cycles);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_result !== want[i]) begin
                errors++; $display("FAIL stall_order: slot %0d got v=%0b %h want %h",
                                   i, out_valid, out_result, want[i]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || stall_cycles !== 16'd3) begin
            errors++; $display("FAIL stall_after: got v=%0b cnt=%0d want 0 3",
                               out_valid, stall_cycles);
        end
    endtask

    task automatic test_branch();
        // beq bne zero dst rw : taken rw_out
        logic [10:0] cases[5];
        logic [10:0] c;
        cases = '{{3'b101, 5'd5, 1'b1, 2'b11}, {3'b011, 5'd5, 1'b1, 2'b01},
                  {3'b110, 5'd5, 1'b1, 2'b11}, {3'b000, 5'd0, 1'b1, 2'b00},
                  {3'b010, 5'd3, 1'b0, 2'b10}};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c = cases[i];
            rand_payload();
            {in_beq, in_bne, in_zero} = c[10:8];
            in_dst_reg = c[7:3]; in_reg_write = c[2]; in_valid = 1'b1;
            step();
            checks++;
            if (out_branch_taken !== c[1] || out_reg_write !== c[0] || out_dst_reg !== c[7:3]) begin
                errors++; $display("FAIL branch_case%0d: got taken=%0b rw=%0b dst=%0d want %0b %0b %0d",
                                   i, out_branch_taken, out_reg_write, out_dst_reg,
                                   c[1], c[0], c[7:3]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_payload(); in_mem_write = 1'b1; in_valid = 1'b1;
            flush = (i == 2);
            step();
        end
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_mem_write !== 1'b0 || in_ready !== 1'b1
            || stall_cycles !== 16'd2) begin
            errors++; $display("FAIL flush_kill: got v=%0b mw=%0b rdy=%0b cnt=%0d want 0 0 1 2",
                               out_valid, out_mem_write, in_ready, stall_cycles);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_leak: cycle %0d got v=%0b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b0;
        rand_payload(); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (stall4 !== 4'd15 || stall_cycles !== 16'd20) begin
            errors++; $display("FAIL saturate: got cnt4=%0d cnt16=%0d want 15 20",
                               stall4, stall_cycles);
        end
        step();
        checks++;
        if (stall4 !== 4'd15) begin
            errors++; $display("FAIL saturate_hold: got %0d want 15", stall4);
        end
    endtask

    task automatic test_random();
        exe_mem_payload_t obs;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rand_payload();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 29) == 0);
            step();
            obs = '{out_result, out_rt_data, out_branch_addr, out_dst_reg, out_zero,
                    out_branch_taken, out_mem_read, out_mem_write, out_mem_to_reg,
                    out_reg_write};
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL rand_hs: cyc %0d got v=%0b rdy=%0b want depth %0d",
                                   n, out_valid, in_ready, q.size());
            end
            checks++;
            if (q.size() > 0) begin
                if (obs !== q[0]) begin
                    errors++; $display("FAIL rand_data: cyc %0d got %h want %h", n, obs, q[0]);
                end
            end else if ({out_mem_read, out_mem_write, out_reg_write, out_branch_taken} !== 4'd0) begin
                errors++; $display("FAIL rand_gate: cyc %0d got ctl=%b want 0000", n,
                                   {out_mem_read, out_mem_write, out_reg_write, out_branch_taken});
            end
            checks++;
            if (stall_cycles !== 16'(m_cnt) || stall4 !== 4'(m_cnt4)) begin
                errors++; $display("FAIL rand_stall: cyc %0d got %0d/%0d want %0d/%0d",
                                   n, stall_cycles, stall4, m_cnt, m_cnt4);
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rand_payload();
        m_cnt = 0; m_cnt4 = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall_cycles !== 16'd0 || out_result !== 32'd0) begin
            errors++; $display("FAIL power_on: got v=%0b cnt=%0d r=%h want 0 0 0",
                               out_valid, stall_cycles, out_result);
        end
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_flush();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
